// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared SISC types: loader states and instruction-memory widths
package sisc_pkg;

  // Instruction-memory geometry shared with the fetch path
  localparam int IM_ADDR_W = 16;
  localparam int INSTR_W   = 32;

  // Loader frame-parsing states
  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    CHK,
    DONE
  } load_state_t;

endpackage

// File: rtl/im_loader_word_pack.sv
// rtl/im_loader_word_pack.sv - big-endian byte-to-word packer for the loader
module word_pack #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic [1:0]        byte_idx,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  // Shift bytes in MSB-first; pulse word_valid the cycle after the 4th byte lands
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      byte_idx   <= 2'd0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clr) begin
      byte_idx   <= 2'd0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_en && (byte_idx == 2'd3);
      if (byte_en) begin
        word     <= {word[WORD_W-9:0], byte_in};
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/im_loader.sv
// rtl/im_loader.sv - framed boot loader writing instruction memory and gating CPU reset
module im_loader
  import sisc_pkg::*;
#(
  parameter int                ADDR_W    = IM_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DATA_W    = INSTR_W
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              cpu_rst_f,
  output logic              load_done,
  output logic              load_err
);

  load_state_t       state;
  logic [7:0]        cnt_hi;
  logic [15:0]       words_left;
  logic [7:0]        xor_acc;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        byte_idx;
  logic              accept;
  logic              hdr_start;
  logic              data_byte;

  // Ready is a pure function of state so it never waits on rx_valid
  assign rx_ready  = (state != DONE);
  assign accept    = rx_valid && rx_ready;
  assign hdr_start = accept && (state == HDR_HI);
  assign data_byte = accept && (state == DATA);
  assign im_addr   = addr_q;

  word_pack #(
    .WORD_W (DATA_W)
  ) u_pack (
    .clk        (clk),
    .rst_f      (rst_f),
    .clr        (hdr_start),
    .byte_en    (data_byte),
    .byte_in    (rx_data),
    .byte_idx   (byte_idx),
    .word       (im_wdata),
    .word_valid (im_we)
  );

  // Frame FSM, remaining-word counter, write address and checksum accumulator
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state      <= HDR_HI;
      cnt_hi     <= 8'd0;
      words_left <= 16'd0;
      xor_acc    <= 8'd0;
      addr_q     <= BASE_ADDR;
      cpu_rst_f  <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      // Address moves on the edge that ends the write cycle
      if (im_we) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      if (accept) begin
        case (state)
          HDR_HI: begin
            cnt_hi   <= rx_data;
            xor_acc  <= 8'd0;
            addr_q   <= BASE_ADDR;
            load_err <= 1'b0;
            state    <= HDR_LO;
          end
          HDR_LO: begin
            words_left <= {cnt_hi, rx_data};
            state      <= ({cnt_hi, rx_data} == 16'd0) ? CHK : DATA;
          end
          DATA: begin
            xor_acc <= xor_acc ^ rx_data;
            if (byte_idx == 2'd3) begin
              words_left <= words_left - 16'd1;
              if (words_left == 16'd1) begin
                state <= CHK;
              end
            end
          end
          CHK: begin
            if (rx_data == xor_acc) begin
              state     <= DONE;
              load_done <= 1'b1;
              cpu_rst_f <= 1'b1;
            end else begin
              state    <= HDR_HI;
              load_err <= 1'b1;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule
